// File: rtl/am_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : am_mod_pkg
// Description : Shared types, limits and elaboration-time helpers for the
//               AM envelope modulator (quadrant enum, saturation limits,
//               quarter-wave sine table generator).
// Revision    : 1.0 - initial release
// ============================================================================
package am_mod_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    localparam int    DEFAULT_DATA_WIDTH = 16;
    localparam int    CARRIER_MAX        = 2**(DEFAULT_DATA_WIDTH-1) - 1;
    localparam int    SAT_MAX            = CARRIER_MAX;
    localparam int    SAT_MIN            = -CARRIER_MAX - 1;
    localparam string ROM_FILE           = "sine_quarter.mem";

    // Largest positive value of a signed sample of the given width.
    function automatic int sat_max(input int width);
        return 2**(width-1) - 1;
    endfunction

    // Most negative value of a signed sample of the given width.
    function automatic int sat_min(input int width);
        return -(2**(width-1));
    endfunction

    // Quarter-wave table entry k: round(amp * sin(pi/2 * (k+0.5) / 2^addr_bits)).
    // Evaluated at elaboration in Q60 fixed point with a Taylor series, so the
    // table contents are generated from the same formula a .mem file encodes
    // and no external file is needed at build time.
    function automatic logic [63:0] sine_entry(input int k, input int addr_bits, input int amp);
        logic signed [127:0] x;
        logic signed [127:0] x2;
        logic signed [127:0] term;
        logic signed [127:0] acc;
        logic signed [127:0] den;
        x    = (128'sh1921FB54442D1846 * 128'(2*k + 1)) >>> (addr_bits + 1);
        x2   = (x * x) >>> 60;
        term = x;
        acc  = x;
        for (int n = 1; n < 16; n++) begin
            den  = 128'((2*n) * (2*n + 1));
            term = -(((term * x2) >>> 60) / den);
            acc  = acc + term;
        end
        return 64'((acc * 128'(amp) + (128'sd1 <<< 59)) >>> 60);
    endfunction

endpackage
`default_nettype wire

// File: rtl/am_envelope_modulator_sine_quarter_rom.sv
`default_nettype none
// ============================================================================
// Module      : sine_quarter_rom
// Description : Quarter-wave sine table, synchronous read, 1-cycle latency.
//               Entry k holds round((2^DATA_BITS-1)*sin(pi/2*(k+0.5)/DEPTH)).
// Revision    : 1.0 - initial release
// ============================================================================
module sine_quarter_rom
    import am_mod_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 15
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [DATA_BITS-1:0] data
);

    logic [DATA_BITS-1:0] rom_table [2**ADDR_BITS];

    for (genvar k = 0; k < 2**ADDR_BITS; k++) begin : g_rom_entry
        localparam logic [63:0] ENTRY = sine_entry(k, ADDR_BITS, 2**DATA_BITS - 1);
        assign rom_table[k] = ENTRY[DATA_BITS-1:0];
    end

    // Registered table read.
    always_ff @(posedge clk) begin
        data <= rom_table[addr];
    end

endmodule
`default_nettype wire

// File: rtl/am_envelope_modulator.sv
`default_nettype none
// ============================================================================
// Module      : am_envelope_modulator
// Description : AM transmitter. Phase accumulator + quarter-wave sine ROM
//               carrier, scaled by a clamped envelope, saturated to a signed
//               DATA_WIDTH sample. sample_en at edge n -> dout_valid at n+3.
//               Optional macro AM_ENV_RAMP_EN slews the envelope by at most
//               ENV_STEP per sample to avoid clicks on envelope steps.
// Revision    : 1.0 - initial release
// ============================================================================
module am_envelope_modulator
    import am_mod_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ENV_WIDTH     = 18,
    parameter int ENV_FRAC      = 15,
    parameter int PHASE_WIDTH   = 32,
    parameter int LUT_ADDR_BITS = 8,
    parameter int ENV_STEP      = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_en,
    input  logic [PHASE_WIDTH-1:0] phase_inc,
    input  logic                   phase_rst,
    input  logic                   env_valid,
    input  logic [ENV_WIDTH-1:0]   env_in,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid
);

    localparam int PROD_WIDTH = ENV_WIDTH + DATA_WIDTH;
    localparam int TOP_BITS   = LUT_ADDR_BITS + 2;
    localparam logic signed [PROD_WIDTH-1:0] SAT_HI = PROD_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [PROD_WIDTH-1:0] SAT_LO = PROD_WIDTH'(sat_min(DATA_WIDTH));

    if (ENV_STEP < 1) begin : g_env_step_check
        $error("ENV_STEP must be at least 1");
    end

    logic [PHASE_WIDTH-1:0]       phase_acc;
    logic [PHASE_WIDTH-1:0]       phase_now;
    logic signed [ENV_WIDTH-1:0]  env_target;
    logic signed [ENV_WIDTH-1:0]  env_use;

    logic                         s1_valid;
    logic [TOP_BITS-1:0]          s1_phase;
    logic signed [ENV_WIDTH-1:0]  s1_env;
    quadrant_t                    quad;
    logic [LUT_ADDR_BITS-1:0]     lut_index;

    logic                         s2_valid;
    logic                         s2_neg;
    logic signed [ENV_WIDTH-1:0]  s2_env;
    logic [DATA_WIDTH-2:0]        rom_data;
    logic signed [DATA_WIDTH-1:0] carrier;

    logic                         s3_valid;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [PROD_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0]        sat_val;

    // phase_rst in a sample cycle makes that sample start at phase 0.
    assign phase_now = phase_rst ? '0 : phase_acc;

    // Phase accumulator: advance per sample, clear on phase_rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_acc <= '0;
        end else if (sample_en) begin
            phase_acc <= phase_now + phase_inc;
        end else if (phase_rst) begin
            phase_acc <= '0;
        end
    end

    // Envelope target register; negative inputs clamp to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            env_target <= '0;
        end else if (env_valid) begin
            env_target <= env_in[ENV_WIDTH-1] ? '0 : env_in;
        end
    end

`ifdef AM_ENV_RAMP_EN
    localparam logic signed [ENV_WIDTH:0]   STEP_W = (ENV_WIDTH+1)'(ENV_STEP);
    localparam logic signed [ENV_WIDTH-1:0] STEP_N = ENV_WIDTH'(ENV_STEP);

    logic signed [ENV_WIDTH-1:0] env_slew;
    logic signed [ENV_WIDTH-1:0] env_slew_next;
    logic signed [ENV_WIDTH:0]   env_diff;

    // Slew toward the target, landing exactly on it when within one step.
    always_comb begin
        env_diff      = {env_target[ENV_WIDTH-1], env_target} - {env_slew[ENV_WIDTH-1], env_slew};
        env_slew_next = env_target;
        if (env_diff > STEP_W) begin
            env_slew_next = env_slew + STEP_N;
        end else if (env_diff < -STEP_W) begin
            env_slew_next = env_slew - STEP_N;
        end
    end

    // Slewed envelope moves once per sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            env_slew <= '0;
        end else if (sample_en) begin
            env_slew <= env_slew_next;
        end
    end

    assign env_use = env_slew_next;
`else
    assign env_use = env_target;
`endif

    // S1: latch the phase top bits and envelope for this sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_phase <= '0;
            s1_env   <= '0;
        end else begin
            s1_valid <= sample_en;
            if (sample_en) begin
                s1_phase <= phase_now[PHASE_WIDTH-1 -: TOP_BITS];
                s1_env   <= env_use;
            end
        end
    end

    // Quadrant fold: odd quadrants read the table mirrored (2^N-1-a == ~a).
    assign quad      = quadrant_t'(s1_phase[TOP_BITS-1 -: 2]);
    assign lut_index = (quad == Q1 || quad == Q3) ? ~s1_phase[LUT_ADDR_BITS-1:0]
                                                  : s1_phase[LUT_ADDR_BITS-1:0];

    sine_quarter_rom #(
        .ADDR_BITS (LUT_ADDR_BITS),
        .DATA_BITS (DATA_WIDTH - 1)
    ) u_rom (
        .clk  (clk),
        .addr (lut_index),
        .data (rom_data)
    );

    // S2: carry sign and envelope alongside the ROM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_neg   <= 1'b0;
            s2_env   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_neg   <= (quad == Q2 || quad == Q3);
            s2_env   <= s1_env;
        end
    end

    assign carrier = s2_neg ? -$signed({1'b0, rom_data}) : $signed({1'b0, rom_data});

    // S3a: full-width signed envelope x carrier product.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            product  <= '0;
        end else begin
            s3_valid <= s2_valid;
            product  <= PROD_WIDTH'(s2_env) * PROD_WIDTH'(carrier);
        end
    end

    // Floor shift back to unity gain, then clip to the output range.
    always_comb begin
        shifted = product >>> ENV_FRAC;
        sat_val = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_HI) begin
            sat_val = SAT_HI[DATA_WIDTH-1:0];
        end else if (shifted < SAT_LO) begin
            sat_val = SAT_LO[DATA_WIDTH-1:0];
        end
    end

    // S3b: output register, holds between valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= s3_valid;
            if (s3_valid) begin
                dout <= sat_val;
            end
        end
    end

endmodule
`default_nettype wire
